// File: rtl/rsa_engine_arbiter_if.sv
// rsa_engine_arbiter_if: requester-side and engine-side signals of the
// RSA engine arbiter, bundled so the arbiter and its environment share one port.
//
// Handshake: a requester raises reqN with dataN stable and keeps both held
// until doneN pulses for one cycle; result/err are valid during that pulse.
// The engine side sees eng_en held high with eng_a/eng_n/eng_e stable until
// the engine answers with a one-cycle eng_ready carrying eng_cipher.
interface rsa_engine_arbiter_if #(
  parameter int DATAWIDTH = 16
);
  logic                 req0;
  logic                 req1;
  logic [DATAWIDTH-1:0] data0;
  logic [DATAWIDTH-1:0] data1;
  logic                 done0;
  logic                 done1;
  logic [DATAWIDTH-1:0] result;
  logic                 err;
  logic                 busy;
  logic                 eng_en;
  logic [DATAWIDTH-1:0] eng_a;
  logic [DATAWIDTH-1:0] eng_n;
  logic [DATAWIDTH-1:0] eng_e;
  logic [DATAWIDTH-1:0] eng_cipher;
  logic                 eng_ready;

  // Arbiter side
  modport master (
    input  req0, req1, data0, data1, eng_cipher, eng_ready,
    output done0, done1, result, err, busy, eng_en, eng_a, eng_n, eng_e
  );

  // Requesters plus engine side
  modport slave (
    output req0, req1, data0, data1, eng_cipher, eng_ready,
    input  done0, done1, result, err, busy, eng_en, eng_a, eng_n, eng_e
  );
endinterface

// File: rtl/rsa_engine_arbiter.sv
// rsa_engine_arbiter: shares one modular-exponentiation engine between an
// encrypt port (0, public exponent) and a decrypt port (1, private exponent).
// Round-robin grant, operand range check, engine enable sequencing, and a
// one-cycle done pulse back to the owning requester.
// Optional engine watchdog: define RSA_ARB_TIMEOUT_EN.
module rsa_engine_arbiter #(
  parameter int DATAWIDTH      = 16,
  parameter int MODULUS        = 1763,
  parameter int PUB_EXP        = 83,
  parameter int PRIV_EXP       = 587
`ifdef RSA_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  rsa_engine_arbiter_if.master        bus,
  output logic [1:0]                  dbg_state
);

  localparam logic [DATAWIDTH-1:0] MOD_W  = DATAWIDTH'(MODULUS);
  localparam logic [DATAWIDTH-1:0] PUB_W  = DATAWIDTH'(PUB_EXP);
  localparam logic [DATAWIDTH-1:0] PRIV_W = DATAWIDTH'(PRIV_EXP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 eng_en_q, eng_en_d;
  logic [DATAWIDTH-1:0] eng_a_q, eng_a_d;
  logic [DATAWIDTH-1:0] eng_e_q, eng_e_d;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 port_q, port_d;   // port owning the current operation
  logic                 last_q, last_d;   // port granted most recently
  logic                 grant1;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  // Next-state and registered-output computation for the arbiter FSM
  always_comb begin
    state_d  = state_q;
    eng_en_d = eng_en_q;
    eng_a_d  = eng_a_q;
    eng_e_d  = eng_e_q;
    result_d = result_q;
    err_d    = err_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    port_d   = port_q;
    last_d   = last_q;
    grant1   = 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // The cycle carrying a done pulse is skipped so that a request still
        // held by the finishing port only counts from the following cycle.
        if (!done0_q && !done1_q && (bus.req0 || bus.req1)) begin
          grant1  = bus.req1 && (!bus.req0 || !last_q);
          port_d  = grant1;
          eng_a_d = grant1 ? bus.data1 : bus.data0;
          eng_e_d = grant1 ? PRIV_W : PUB_W;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (eng_a_q >= MOD_W) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          eng_en_d = 1'b1;
          state_d  = S_RUN;
`ifdef RSA_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_RUN: begin
        if (bus.eng_ready) begin
          result_d = bus.eng_cipher;
          err_d    = 1'b0;
          eng_en_d = 1'b0;
          state_d  = S_DONE;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          eng_en_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        done0_d = !port_q;
        done1_d = port_q;
        last_d  = port_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      eng_en_q <= 1'b0;
      eng_a_q  <= '0;
      eng_e_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      eng_en_q <= eng_en_d;
      eng_a_q  <= eng_a_d;
      eng_e_q  <= eng_e_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      port_q   <= port_d;
      last_q   <= last_d;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.eng_en = eng_en_q;
  assign bus.eng_a  = eng_a_q;
  assign bus.eng_e  = eng_e_q;
  assign bus.eng_n  = MOD_W;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// tb_rsa_engine_arbiter: directed bench for rsa_engine_arbiter with a
// behavioural exponentiation engine and a done-pulse scoreboard.
module tb_rsa_engine_arbiter;
  localparam int W       = 16;
  localparam int TIMEOUT = 4096;
  localparam int ENG_LAT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  rsa_engine_arbiter_if #(.DATAWIDTH(W)) bus ();

  rsa_engine_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int eng_start_count = 0;
  logic hang = 1'b0;

  logic [W+1:0]   exp_q[$];   // {port, err, result}
  logic [2*W-1:0] eng_q[$];   // {eng_e, eng_a} expected at each engine start

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [31:0] r;
    logic [31:0] x;
    r = 32'd1;
    x = 32'(b) % 32'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 32'(m);
      x = (x * x) % 32'(m);
    end
    return r[W-1:0];
  endfunction

  logic en_prev;
  logic eng_active;
  int   eng_cnt;
  logic [2*W-1:0] eng_exp;

  always @(negedge clk) begin
    if (!rst) begin
      en_prev        <= 1'b0;
      eng_active     <= 1'b0;
      eng_cnt        <= 0;
      bus.eng_ready  <= 1'b0;
      bus.eng_cipher <= '0;
    end else begin
      en_prev       <= bus.eng_en;
      bus.eng_ready <= 1'b0;
      if (bus.eng_en && !en_prev) begin
        eng_start_count++;
        check("eng_n", 32'(bus.eng_n), 32'd1763);
        if (eng_q.size() == 0) begin
          check("eng_start_unexpected", 32'(eng_start_count), 32'd0);
        end else begin
          eng_exp = eng_q.pop_front();
          check("eng_e", 32'(bus.eng_e), 32'(eng_exp[2*W-1:W]));
          check("eng_a", 32'(bus.eng_a), 32'(eng_exp[W-1:0]));
        end
        bus.eng_cipher <= modexp(bus.eng_a, bus.eng_e, bus.eng_n);
        eng_active     <= !hang;
        eng_cnt        <= 1;
      end else if (eng_active) begin
        if (eng_cnt == ENG_LAT - 1) begin
          bus.eng_ready <= 1'b1;
          eng_active    <= 1'b0;
        end
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [W+1:0] got_exp;

  always @(negedge clk) begin
    if (rst && (bus.done0 || bus.done1)) begin
      done_count++;
      check("done_exclusive", 32'(bus.done0 && bus.done1), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done0=%0d done1=%0d expected no done",
                 bus.done0, bus.done1);
      end else begin
        got_exp = exp_q.pop_front();
        check("done_port",   32'(bus.done1),  32'(got_exp[W+1]));
        check("done_err",    32'(bus.err),    32'(got_exp[W]));
        check("done_result", 32'(bus.result), 32'(got_exp[W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Raises one request, waits (bounded) for its done, then drops it.
  // Cycle counts are negedges after the request was driven.
  task automatic run_req(input bit port, input logic [W-1:0] d, input int max_cyc,
                         output int t_en, output int t_off, output int t_done);
    int c;
    bit got;
    t_en = -1; t_off = -1; t_done = -1; got = 1'b0; c = 0;
    @(negedge clk);
    if (port) begin bus.data1 = d; bus.req1 = 1'b1; end
    else      begin bus.data0 = d; bus.req0 = 1'b1; end
    while (!got && c < max_cyc) begin
      @(negedge clk); #1;
      c++;
      if (bus.eng_en && t_en < 0) t_en = c;
      if (!bus.eng_en && t_en >= 0 && t_off < 0) t_off = c;
      if (port ? bus.done1 : bus.done0) begin got = 1'b1; t_done = c; end
    end
    if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done on port %0d within %0d cycles", port, max_cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  int t_en, t_off, t_done, n0, e0, c;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = '0;  bus.data1 = '0;
    do_reset();
    #1;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_eng_en", 32'(bus.eng_en), 32'd0);
    check("rst_done0",  32'(bus.done0),  32'd0);
    check("rst_done1",  32'(bus.done1),  32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_eng_a",  32'(bus.eng_a),  32'd0);
    check("rst_eng_e",  32'(bus.eng_e),  32'd0);
    check("rst_eng_n",  32'(bus.eng_n),  32'd1763);
    check("rst_state",  32'(dbg_state),  32'd0);

    // Single encrypt: 2^83 mod 1763 = 1484
    eng_q.push_back({16'd83, 16'd2});
    exp_q.push_back({1'b0, 1'b0, 16'd1484});
    run_req(1'b0, 16'd2, 300, t_en, t_off, t_done);
    check("enc_en_latency", 32'(t_en), 32'd2);
    repeat (3) @(negedge clk);

    // Round trip: 1000^83 mod 1763 = 1595, 1595^587 mod 1763 = 1000
    eng_q.push_back({16'd83, 16'd1000});
    exp_q.push_back({1'b0, 1'b0, 16'd1595});
    run_req(1'b0, 16'd1000, 300, t_en, t_off, t_done);
    repeat (2) @(negedge clk);
    eng_q.push_back({16'd587, 16'd1595});
    exp_q.push_back({1'b1, 1'b0, 16'd1000});
    run_req(1'b1, 16'd1595, 300, t_en, t_off, t_done);
    repeat (4) @(negedge clk); #1;
    check("result_hold", 32'(bus.result), 32'd1000);

    // Range check: 1763 rejected without touching the engine
    n0 = eng_start_count;
    exp_q.push_back({1'b1, 1'b1, 16'd0});
    run_req(1'b1, 16'd1763, 50, t_en, t_off, t_done);
    check("reject_done_latency", 32'(t_done), 32'd3);
    check("reject_no_eng_en", 32'(eng_start_count - n0), 32'd0);
    check("reject_en_seen", 32'(t_en), 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    // Largest legal operand: (-1)^587 = -1 = 1762
    eng_q.push_back({16'd587, 16'd1762});
    exp_q.push_back({1'b1, 1'b0, 16'd1762});
    run_req(1'b1, 16'd1762, 300, t_en, t_off, t_done);
    repeat (2) @(negedge clk);

    // Contention from reset: grants alternate 0,1,0,1
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 16'd2; bus.data1 = 16'd1484;
    for (int i = 0; i < 2; i++) begin
      eng_q.push_back({16'd83, 16'd2});
      exp_q.push_back({1'b0, 1'b0, 16'd1484});
      eng_q.push_back({16'd587, 16'd1484});
      exp_q.push_back({1'b1, 1'b0, 16'd2});
    end
    do_reset();
    e0 = done_count;
    c = 0;
    while (done_count - e0 < 4 && c < 600) begin
      @(negedge clk); #1;
      c++;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("contention_dones", 32'(done_count - e0), 32'd4);
    repeat (4) @(negedge clk);

    // Reset mid-RUN: outputs clear at once, port 0 wins afterwards
    eng_q.push_back({16'd83, 16'd2});
    @(negedge clk);
    bus.data0 = 16'd2; bus.req0 = 1'b1;
    c = 0;
    while (!bus.eng_en && c < 20) begin @(negedge clk); #1; c++; end
    check("midrun_en_reached", 32'(bus.eng_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrun_eng_en", 32'(bus.eng_en), 32'd0);
    check("midrun_busy",   32'(bus.busy),   32'd0);
    check("midrun_done0",  32'(bus.done0),  32'd0);
    check("midrun_done1",  32'(bus.done1),  32'd0);
    check("midrun_state",  32'(dbg_state),  32'd0);
    bus.data1 = 16'd1484; bus.req1 = 1'b1;
    eng_q.push_back({16'd83, 16'd2});
    exp_q.push_back({1'b0, 1'b0, 16'd1484});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    e0 = done_count;
    c = 0;
    while (done_count == e0 && c < 300) begin @(negedge clk); #1; c++; end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("post_reset_done", 32'(done_count - e0), 32'd1);
    repeat (4) @(negedge clk);

    // Engine never answers
    hang = 1'b1;
    eng_q.push_back({16'd83, 16'd5});
`ifdef RSA_ARB_TIMEOUT_EN
    exp_q.push_back({1'b0, 1'b1, 16'd0});
    run_req(1'b0, 16'd5, TIMEOUT + 100, t_en, t_off, t_done);
    check("timeout_run_cycles", 32'(t_off - t_en), 32'(TIMEOUT));
`else
    e0 = done_count;
    @(negedge clk);
    bus.data0 = 16'd5; bus.req0 = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    check("hang_busy",  32'(bus.busy),   32'd1);
    check("hang_state", 32'(dbg_state),  32'd2);
    check("hang_no_done", 32'(done_count - e0), 32'd0);
    bus.req0 = 1'b0;
    do_reset();
`endif
    hang = 1'b0;
    repeat (4) @(negedge clk);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("eng_q_empty", 32'(eng_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_engine_arbiter.md
# rsa_engine_arbiter

Shares a single modular-exponentiation engine (`encrpytion`-style: `en` / `a` / `n` / `e` in; `cipher` / `ready_flag` out) between two requesters: port 0 encrypts with the public exponent, port 1 decrypts with the private exponent. It performs round-robin arbitration and operand range checking, and sequences the engine enable. It returns each result to the requester that issued it with a one-cycle done pulse. It sits between the push-button front ends and the engine, replacing their direct engine instantiation.

## Interface
- `DATAWIDTH`, 16: operand, result and engine port width.
- `MODULUS`, 1763: RSA modulus n (41·43).
- `PUB_EXP`, 83: exponent for port 0.
- `PRIV_EXP`, 587: exponent for port 1 (83·587 ≡ 1 mod 1680).
- `TIMEOUT_CYCLES`, 4096: engine watchdog limit (used only with the macro).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  level request; held with operand stable until matching done.
- `data0`, `data1`  in  DATAWIDTH  operand (plaintext / ciphertext).
- `done0`, `done1`  out  1  one-cycle completion pulse to the owning requester.
- `result`  out  DATAWIDTH  result, valid while a done pulse is high and held until the next done.
- `err`  out  1  high with a done pulse when the operation was rejected or timed out.
- `busy`  out  1  high in every state except IDLE.
- `eng_en`  out  1  engine enable.
- `eng_a`, `eng_n`, `eng_e`  out  DATAWIDTH  engine operand, modulus and exponent.
- `eng_cipher`  in  DATAWIDTH  engine result.
- `eng_ready`  in  1  engine completion.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- **IDLE:** if any request is high, grant one. With a single request, that requester wins. With both high, the winner is the port not granted last (`last` pointer; port 0 wins first after reset). On grant:
  - latch the operand into `eng_a`;
  - set `eng_e` to the port's exponent;
  - record the port;
  - go to LOAD.
- **LOAD:** range check.
  - Operand ≥ MODULUS: skip the engine, set `err`=1 and `result`=0, go to DONE.
  - Otherwise set `eng_en`=1 and go to RUN.
- **RUN:** hold `eng_en`=1 until `eng_ready`=1. Then latch `eng_cipher` into `result`, set `err`=0, `eng_en`=0, and go to DONE.
- **DONE:** pulse the granted port's done for one cycle, update `last`, and go to IDLE.
- Request handling:
  - A request still high in the cycle after its done counts as a new request.
  - Requests that arrive or change outside IDLE are ignored until IDLE. Operands are sampled only at grant.
- `eng_n` is constantly MODULUS. `eng_a` and `eng_e` are held from grant until the next grant.
- Reset (asynchronous, any state, including mid-RUN):
  - state → IDLE;
  - `eng_en`, `done0`, `done1`, `err`, `busy`, `result`, `eng_a`, `eng_e` → 0;
  - `eng_n` → MODULUS;
  - `last` → 1, so port 0 has priority next.
- An in-flight operation is abandoned silently on reset: no done pulse is issued.

## Timing
- Request high in IDLE at edge T:
  - grant and `busy`=1 at T+1 (LOAD);
  - `eng_en`=1 at T+2.
- `eng_ready` sampled high at edge R: `eng_en`=0, `result` valid and state = DONE at R+1; done pulse high for the single cycle following R+1.
- Back-to-back throughput: next grant no earlier than 2 cycles after the done pulse ends (DONE → IDLE → grant).
- Rejected operand: done pulse 3 cycles after the request is seen in IDLE, with `eng_en` never asserted.
- `eng_ready` outside RUN is ignored.

## Configuration
- Macro `RSA_ARB_TIMEOUT_EN`.
- **Defined:** a cycle counter clears on entry to RUN and counts each RUN cycle. If it reaches TIMEOUT_CYCLES without `eng_ready`:
  - drop `eng_en`, set `err`=1 and `result`=0, go to DONE;
  - the counter is reset-cleared.
- **Undefined:** no counter exists, and RUN waits for `eng_ready` indefinitely.

## Test plan
- **Single encrypt:** `req0`=1, `data0`=2, engine model returns 2^83 mod 1763 after 20 cycles → `done0` pulse, `result`=that value, `err`=0, `done1` stays 0.
- **Round trip:** encrypt 1000 on port 0, then feed the ciphertext to port 1 → port 1 `result`=1000; `eng_e` observed as 83, then 587.
- **Contention:** `req0` and `req1` both high from reset and kept high → grants alternate 0,1,0,1; each done lands on the correct port.
- **Range check:** `data1`=1763 → `done1` with `err`=1 and `result`=0, `eng_en` never high.
- **Reset mid-RUN:** `rst`=0 while `eng_en`=1 → `eng_en`, `busy` and `done*` go to 0 immediately (asynchronously); after release, port 0 wins a simultaneous request.
- **Timeout (macro defined):** engine model never asserts ready → `err`=1 done exactly at TIMEOUT_CYCLES cycles after entering RUN. Without the macro, `busy` stays high.
